// File: rtl/fir_seq_ctrl_if.sv
// Handshake/bus bundle between the codec/testbench side and the FIR sequencing controller.
interface fir_seq_ctrl_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              smpl_valid;
    logic              flush;
    logic              q_wr_en;
    logic [ADDR_W-1:0] q_wr_addr;
    logic [ADDR_W-1:0] q_rd_addr;
    logic [ADDR_W-1:0] tap_idx;
    logic              sequencing;
    logic              filt_done;
    logic              busy;
    logic              q_full;
    logic              overrun;

    modport master (
        output smpl_valid, flush,
        input  q_wr_en, q_wr_addr, q_rd_addr, tap_idx,
        input  sequencing, filt_done, busy, q_full, overrun
    );

    modport slave (
        input  smpl_valid, flush,
        output q_wr_en, q_wr_addr, q_rd_addr, tap_idx,
        output sequencing, filt_done, busy, q_full, overrun
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Sequences the shared FIR datapath: logs samples into a circular queue and runs one
// oldest-to-newest convolution pass per new sample once TAPS samples are held.
module fir_seq_ctrl #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned TAPS     = 1021,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned PIPE_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    fir_seq_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(TAPS + 1);
    localparam int unsigned LAT_W = $clog2(PIPE_LAT + 1);
    localparam logic [ADDR_W-1:0] PTR_MASK  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  FILL_MAX  = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0]  FILL_TRIG = CNT_W'(TAPS - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(PIPE_LAT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            r_state;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_tap;
    logic [CNT_W-1:0]  r_fill;
    logic [LAT_W-1:0]  r_lat;
    logic              r_seq;
    logic              r_done;
    logic              r_busy;
    logic              r_full;
    logic              r_ovr;
    logic              r_pending;

    logic [ADDR_W-1:0] w_wr_next;
    logic [ADDR_W-1:0] w_newest;
    logic [CNT_W-1:0]  w_fill_next;
    logic              w_idle_arrival;
    logic              w_start;

    // w_wr_next is the slot the next sample lands in, accounting for a write still in flight
    always_comb begin
        w_wr_next      = r_wr_en ? ((r_wr_addr + ONE_A) & PTR_MASK) : r_wr_addr;
        w_fill_next    = (bus.smpl_valid && (r_fill != FILL_MAX)) ? (r_fill + CNT_W'(1)) : r_fill;
        w_idle_arrival = (r_state == S_IDLE) && bus.smpl_valid && (r_fill >= FILL_TRIG);
        w_start        = w_idle_arrival || ((r_state == S_IDLE) && r_pending);
        w_newest       = w_idle_arrival ? w_wr_next : ((w_wr_next - ONE_A) & PTR_MASK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_tap     <= '0;
            r_fill    <= '0;
            r_lat     <= '0;
            r_seq     <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_full    <= 1'b0;
            r_ovr     <= 1'b0;
            r_pending <= 1'b0;
        end else if (bus.flush) begin
            r_state   <= S_IDLE;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_tap     <= '0;
            r_fill    <= '0;
            r_lat     <= '0;
            r_seq     <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_full    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_wr_en   <= bus.smpl_valid;
            r_wr_addr <= w_wr_next;
            r_fill    <= w_fill_next;
            r_full    <= (w_fill_next == FILL_MAX);
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_RUN;
                        r_seq     <= 1'b1;
                        r_busy    <= 1'b1;
                        r_tap     <= '0;
                        r_rd_addr <= (w_newest - LAST_TAP) & PTR_MASK;
                        r_pending <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.smpl_valid) begin
                        if (r_pending) r_ovr <= 1'b1;
                        else           r_pending <= 1'b1;
                    end
                    if (r_tap == LAST_TAP) begin
                        r_state <= S_DRAIN;
                        r_lat   <= LAT_W'(1);
                    end else begin
                        r_tap     <= r_tap + ONE_A;
                        r_rd_addr <= (r_rd_addr + ONE_A) & PTR_MASK;
                    end
                end
                S_DRAIN: begin
                    if (bus.smpl_valid) begin
                        if (r_pending) r_ovr <= 1'b1;
                        else           r_pending <= 1'b1;
                    end
                    // hold the last tap until the final product has left the ROM/queue pipe
                    if (r_lat == LAT_LAST) begin
                        r_state <= S_IDLE;
                        r_seq   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.q_wr_en    = r_wr_en;
    assign bus.q_wr_addr  = r_wr_addr;
    assign bus.q_rd_addr  = r_rd_addr;
    assign bus.tap_idx    = r_tap;
    assign bus.sequencing = r_seq;
    assign bus.filt_done  = r_done;
    assign bus.busy       = r_busy;
    assign bus.q_full     = r_full;
    assign bus.overrun    = r_ovr;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: directed scenario sequence with randomized strobe spacing,
// every cycle compared against a pass-timeline reference model.
module tb_fir_seq_ctrl;
    localparam int DEPTH    = 1024;
    localparam int TAPS     = 1021;
    localparam int ADDR_W   = 10;
    localparam int PIPE_LAT = 1;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;

    // reference model: write pointer, fill, and one pass described by start cycle + newest slot
    int   m_w;
    int   m_fill;
    logic m_wr_en;
    logic m_active;
    int   m_start;
    int   m_newest;
    logic m_pending;
    logic m_ovr;

    fir_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    fir_seq_ctrl #(
        .DEPTH(DEPTH), .TAPS(TAPS), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_w = 0; m_fill = 0; m_wr_en = 1'b0; m_active = 1'b0;
        m_start = 0; m_newest = 0; m_pending = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wr_en"}, bus.q_wr_en, 0);
        chk({tag, "_wr_addr"}, bus.q_wr_addr, 0);
        chk({tag, "_rd_addr"}, bus.q_rd_addr, 0);
        chk({tag, "_tap"}, bus.tap_idx, 0);
        chk({tag, "_seq"}, bus.sequencing, 0);
        chk({tag, "_done"}, bus.filt_done, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_full"}, bus.q_full, 0);
        chk({tag, "_ovr"}, bus.overrun, 0);
    endtask

    task automatic check_model();
        int   k;
        int   tap_e;
        int   rd_e;
        logic seq_e;
        logic fd_e;
        k     = cyc - m_start;
        seq_e = m_active && (k < TAPS + PIPE_LAT);
        fd_e  = m_active && (k == TAPS + PIPE_LAT);
        chk("wr_en", bus.q_wr_en, m_wr_en);
        chk("wr_addr", bus.q_wr_addr, m_w);
        chk("sequencing", bus.sequencing, seq_e);
        chk("busy", bus.busy, seq_e);
        chk("filt_done", bus.filt_done, fd_e);
        chk("q_full", bus.q_full, m_fill == TAPS);
        chk("overrun", bus.overrun, m_ovr);
        if (seq_e) begin
            tap_e = (k < TAPS) ? k : TAPS - 1;
            rd_e  = (k < TAPS) ? (((m_newest - (TAPS - 1) + k) % DEPTH) + DEPTH) % DEPTH : m_newest;
            chk("tap_idx", bus.tap_idx, tap_e);
            chk("rd_addr", bus.q_rd_addr, rd_e);
        end
    endtask

    task automatic step(input logic sv, input logic fl);
        int   k;
        logic fd_now;
        logic idle_now;
        bus.smpl_valid = sv;
        bus.flush      = fl;
        @(posedge clk);
        k        = cyc - m_start;
        fd_now   = m_active && (k == TAPS + PIPE_LAT);
        idle_now = !m_active || fd_now;
        cyc++;
        if (rst) begin
            model_reset();
        end else if (fl) begin
            m_active = 1'b0; m_pending = 1'b0; m_fill = 0; m_w = 0; m_wr_en = 1'b0;
        end else begin
            if (m_wr_en) m_w = (m_w + 1) % DEPTH;
            m_wr_en = sv;
            if (idle_now) begin
                if (sv && m_fill >= TAPS - 1) begin
                    m_active = 1'b1; m_start = cyc; m_newest = m_w; m_pending = 1'b0;
                end else if (m_pending) begin
                    m_active = 1'b1; m_start = cyc; m_newest = (m_w + DEPTH - 1) % DEPTH; m_pending = 1'b0;
                end else begin
                    m_active = 1'b0;
                end
            end else if (sv) begin
                if (m_pending) m_ovr = 1'b1;
                else           m_pending = 1'b1;
            end
            if (sv && m_fill < TAPS) m_fill++;
        end
        #1;
        bus.smpl_valid = 1'b0;
        bus.flush      = 1'b0;
        check_model();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (m_active && n < 5000) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk({tag, "_idle_timeout"}, m_active, 0);
    endtask

    task automatic go_to_tap(input string tag, input int t);
        int n;
        n = 0;
        while (!(m_active && (cyc - m_start) == t) && n < 5000) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk({tag, "_tap_timeout"}, (m_active && (cyc - m_start) == t), 1);
    endtask

    task automatic fill_strobes(input int cnt, input int slow);
        for (int i = 0; i < cnt; i++) begin
            step(1'b1, 1'b0);
            repeat ((i < slow) ? 49 : $urandom_range(0, 3)) step(1'b0, 1'b0);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        model_reset();
        rst = 1'b1;
        bus.smpl_valid = 1'b0;
        bus.flush      = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_zero("reset");
        rst = 1'b0;

        // fill to TAPS-1 samples: no pass may start
        fill_strobes(TAPS - 1, 20);
        chk("fill_not_full", bus.q_full, 0);
        chk("fill_wr_addr", bus.q_wr_addr, TAPS - 1);
        step(1'b1, 1'b0);
        chk("first_pass_seq", bus.sequencing, 1);
        chk("first_pass_rd0", bus.q_rd_addr, 0);
        chk("first_pass_full", bus.q_full, 1);
        wait_idle("pass1");

        // pending: one strobe mid-pass queues a pass, a second one in the next pass overruns
        step(1'b1, 1'b0);
        go_to_tap("pendA", 300);
        step(1'b1, 1'b0);
        chk("pend_no_ovr", bus.overrun, 0);
        go_to_tap("pendB", 100);
        step(1'b1, 1'b0);
        go_to_tap("pendB2", 200);
        step(1'b1, 1'b0);
        chk("ovr_set", bus.overrun, 1);
        wait_idle("pendC");

        // walk the write pointer to 5 with full-queue passes, then check the wrapped read window
        for (int i = 0; i < 8 && m_w != 5; i++) begin
            step(1'b1, 1'b0);
            wait_idle("walk");
        end
        chk("walk_w5", bus.q_wr_addr, 5);
        step(1'b1, 1'b0);
        chk("wrap_rd_start", bus.q_rd_addr, 9);
        wait_idle("wrap");

        // flush mid-pass
        step(1'b1, 1'b0);
        go_to_tap("flush", 500);
        step(1'b0, 1'b1);
        chk("flush_seq", bus.sequencing, 0);
        chk("flush_busy", bus.busy, 0);
        chk("flush_wr_addr", bus.q_wr_addr, 0);
        chk("flush_ovr_kept", bus.overrun, 1);
        repeat (20) step(1'b0, 1'b0);
        fill_strobes(TAPS - 1, 0);
        chk("refill_no_pass", bus.busy, 0);
        step(1'b1, 1'b0);
        chk("refill_pass_rd0", bus.q_rd_addr, 0);
        wait_idle("refill");

        // asynchronous reset mid-pass
        step(1'b1, 1'b0);
        go_to_tap("areset", 700);
        #2 rst = 1'b1;
        #1;
        check_zero("areset");
        model_reset();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        fill_strobes(TAPS - 1, 0);
        chk("post_rst_no_pass", bus.sequencing, 0);
        chk("post_rst_not_full", bus.q_full, 0);
        repeat (10) step(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
